wb_burst_master: RTL
====================

Name: wb_burst_master

Overview:
- Wishbone B3 burst master that drives the Wishbone slave port of the SDRAM controller top.
- Turns simple command-channel requests (address, length, direction) into incrementing bursts with cycle-type tags.
- Write data comes from an internal show-ahead write FIFO; read data is streamed out beat by beat.
- A no-ack watchdog aborts stalled bursts so the bus cannot hang.

Parameters:
- APP_AW, 26, byte address width; matches the controller's wb_addr_i.
- dw, 32, Wishbone data width; byte-enable width is dw/8.
- bl, 9, burst-length field width in words.
- WFIFO_AW, 3, write-FIFO address width; depth is 2**WFIFO_AW = 8.
- TMO_W, 10, watchdog counter width; abort after 2**TMO_W-1 cycles without ack.

Ports:
- wb_clk_i  in  1  single clock for the whole block
- wb_resetn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_addr  in  APP_AW  start byte address; bits [log2(dw/8)-1:0] are ignored (forced 0)
- cmd_len  in  bl  burst length in words
- cmd_we  in  1  1 = write, 0 = read
- wdata_valid  in  1  write-data push
- wdata_ready  out  1  write FIFO not full
- wdata  in  dw  write data
- wsel  in  dw/8  byte enables stored alongside wdata
- rdata_valid  out  1  read beat valid; no backpressure
- rdata  out  dw  read data
- rdata_last  out  1  final beat of a read burst
- done  out  1  one-cycle pulse when a command completes
- err  out  1  qualifies done; 1 = watchdog abort
- busy  out  1  command in progress
- wb_cyc_o  out  1  Wishbone cycle
- wb_stb_o  out  1  Wishbone strobe
- wb_we_o  out  1  Wishbone write enable
- wb_addr_o  out  APP_AW  Wishbone byte address
- wb_dat_o  out  dw  Wishbone write data
- wb_sel_o  out  dw/8  Wishbone byte select
- wb_cti_o  out  3  Wishbone cycle type
- wb_ack_i  in  1  Wishbone ack
- wb_dat_i  in  dw  Wishbone read data

Behaviour:
- Reset (async, wb_resetn=0):
  - All outputs 0 except cmd_ready=1 and wdata_ready=1.
  - FIFO emptied, FSM to IDLE, counters cleared.
  - Reset mid-burst drops cyc/stb immediately; no done pulse.
- FSM states: IDLE, BURST, FINISH.
- IDLE:
  - cmd_ready=1.
  - On handshake, latch addr (aligned), len and we into remain/addr registers.
  - len=0: go to FINISH with no bus activity.
  - Otherwise: go to BURST, with wb_cyc_o=1 from the next cycle.
- BURST:
  - wb_cyc_o=1 throughout; wb_we_o equals the latched cmd_we.
  - Read: wb_stb_o=1 continuously.
  - Write: wb_stb_o = FIFO non-empty. If the FIFO is empty, insert a master wait state: stb=0, cyc held, cti/addr held.
  - wb_dat_o and wb_sel_o = FIFO head (show-ahead). FIFO pops on ack during a write.
  - wb_cti_o = 3'b010 while remain>1; 3'b111 when remain==1 (this includes len=1).
  - On each ack: wb_addr_o += dw/8 (wraps modulo 2**APP_AW); remain -= 1.
  - Read ack: rdata_valid=1 in the same cycle (combinational from wb_ack_i & read); rdata=wb_dat_i; rdata_last = (remain==1).
  - Ack with remain==1: deassert cyc/stb next cycle and go to FINISH.
  - wb_ack_i while cyc=0 is ignored.
- Watchdog:
  - Counter clears on any ack or wait state; increments while stb=1 & !ack.
  - At all-ones: drop cyc/stb next cycle, flush the write FIFO, set err, go to FINISH.
- FINISH:
  - done=1 for one cycle; err held valid with done.
  - Then go to IDLE. busy=1 in BURST and FINISH.
- Write FIFO:
  - Push allowed in any state (pre-fill); push while full is dropped.
  - Simultaneous push and pop when full is legal (count unchanged).
  - Pop when empty is impossible by construction.
  - wdata_ready = !full.
- cmd_valid in BURST/FINISH is held off (cmd_ready=0). There is no command queue.

Decomposition:
- Package wb_burst_pkg: CTI constants (CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111) and the FSM state enum.
- Sub-module wb_sync_fifo:
  - Parameterised width (dw+dw/8) and WFIFO_AW.
  - Show-ahead, with full/empty and synchronous flush.
  - Async active-low reset on wb_resetn.

Test Plan:
- Read burst: cmd addr=0x100, len=4, we=0; slave acks every cycle.
  - Expect wb_addr_o 0x100, 0x104, 0x108, 0x10C.
  - Expect cti 010, 010, 010, 111.
  - Expect 4 rdata_valid beats, rdata_last on the 4th, done=1 and err=0 one cycle after cyc drops.
- Write with starvation: prefill 2 words, cmd len=4 we=1, push words 3 and 4 after 5 idle cycles.
  - Expect stb=0 and cyc=1 during the gap, addr held, and exactly 4 acked beats carrying the pushed data and sel in order.
- Single beat and len=0:
  - len=1: expect cti=111 on the only beat.
  - len=0: expect no cyc, and done one cycle after acceptance.
- Watchdog: read len=2, slave never acks.
  - Expect cyc drop after 1023 stalled cycles, then done=1 with err=1, and the FIFO empty.
- Address wrap: cmd_addr=2**26-8, len=3.
  - Expect addresses 0x3FFFFF8, 0x3FFFFFC, 0x0000000.
- Reset mid-burst: assert wb_resetn=0 on the 2nd beat of a len=8 write.
  - Expect cyc/stb=0 asynchronously, no done pulse, and cmd_ready=1 after release.

Source files
------------

// File: rtl/wb_burst_pkg.sv
// Shared types and constants for the Wishbone burst master.
package wb_burst_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/wb_burst_master_if.sv
// Command, write-data, read-data, status and Wishbone signals of the burst master.
interface wb_burst_master_if #(
  parameter int APP_AW = 26,
  parameter int dw     = 32,
  parameter int bl     = 9
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [APP_AW-1:0] cmd_addr;
  logic [bl-1:0]     cmd_len;
  logic              cmd_we;

  logic              wdata_valid;
  logic              wdata_ready;
  logic [dw-1:0]     wdata;
  logic [dw/8-1:0]   wsel;

  logic              rdata_valid;
  logic [dw-1:0]     rdata;
  logic              rdata_last;

  logic              done;
  logic              err;
  logic              busy;

  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [APP_AW-1:0] wb_addr_o;
  logic [dw-1:0]     wb_dat_o;
  logic [dw/8-1:0]   wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic              wb_ack_i;
  logic [dw-1:0]     wb_dat_i;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, cmd_we,
    input  wdata_valid, wdata, wsel,
    input  wb_ack_i, wb_dat_i,
    output cmd_ready, wdata_ready,
    output rdata_valid, rdata, rdata_last,
    output done, err, busy,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, cmd_we,
    output wdata_valid, wdata, wsel,
    output wb_ack_i, wb_dat_i,
    input  cmd_ready, wdata_ready,
    input  rdata_valid, rdata, rdata_last,
    input  done, err, busy,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o
  );

endinterface

// File: rtl/wb_sync_fifo.sv
// Show-ahead synchronous FIFO with full/empty flags and a synchronous flush.
module wb_sync_fifo #(
  parameter int W  = 36,
  parameter int AW = 3
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  input  logic         i_flush,
  output logic [W-1:0] o_rdata,
  output logic         o_full,
  output logic         o_empty
);

  localparam int DEPTH = 2 ** AW;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);

  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push = i_push & (~o_full | i_pop);
  assign w_pop  = i_pop & ~o_empty;

  // Head is forced to zero while empty so stale entries never reach the bus.
  assign o_rdata = o_empty ? '0 : r_mem[r_rptr];

  // NOTE: storage is deliberately not reset; the pointers and count define
  // what is valid, and a reset on the array would cost a flop reset per bit.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // NOTE: every sequential assignment uses <= so all registers sample the
  // pre-edge values; blocking = here would make the order of lines matter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone B3 incrementing-burst master with a write FIFO and a no-ack watchdog.
module wb_burst_master
  import wb_burst_pkg::*;
#(
  parameter int APP_AW   = 26,
  parameter int dw       = 32,
  parameter int bl       = 9,
  parameter int WFIFO_AW = 3,
  parameter int TMO_W    = 10
) (
  input  logic             wb_clk_i,
  input  logic             wb_resetn,
  wb_burst_master_if.master bus
);

  localparam int                SW        = dw / 8;
  localparam int                FW        = dw + SW;
  localparam logic [APP_AW-1:0] ADDR_STEP = APP_AW'(SW);
  localparam logic [APP_AW-1:0] ADDR_MASK = ~APP_AW'(SW - 1);
  // The stall that would bring the counter to all-ones is the one that aborts.
  localparam logic [TMO_W-1:0]  TMO_ARM   = TMO_W'(2 ** TMO_W - 2);

  state_t            r_state;
  logic [APP_AW-1:0] r_addr;
  logic [bl-1:0]     r_remain;
  logic              r_we;
  logic              r_cyc;
  logic              r_done;
  logic              r_err;
  logic [TMO_W-1:0]  r_tmo;

  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic          w_fifo_pop;
  logic [FW-1:0] w_fifo_head;
  logic          w_stb;
  logic          w_ack;
  logic          w_last;
  logic          w_stall;
  logic          w_tmo_hit;
  logic          w_rd_ack;

  // A write with nothing queued becomes a master wait state: cyc held, stb low.
  assign w_stb      = r_cyc & (~r_we | ~w_fifo_empty);
  assign w_ack      = w_stb & bus.wb_ack_i;
  assign w_last     = (r_remain == bl'(1));
  assign w_stall    = w_stb & ~bus.wb_ack_i;
  assign w_tmo_hit  = w_stall & (r_tmo == TMO_ARM);
  assign w_rd_ack   = w_ack & ~r_we;
  assign w_fifo_pop = w_ack & r_we;

  wb_sync_fifo #(
    .W  (FW),
    .AW (WFIFO_AW)
  ) u_wfifo (
    .i_clk   (wb_clk_i),
    .i_rst_n (wb_resetn),
    .i_push  (bus.wdata_valid),
    .i_wdata ({bus.wsel, bus.wdata}),
    .i_pop   (w_fifo_pop),
    .i_flush (w_tmo_hit),
    .o_rdata (w_fifo_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge wb_clk_i or negedge wb_resetn) begin
    if (!wb_resetn) begin
      r_state  <= ST_IDLE;
      r_addr   <= '0;
      r_remain <= '0;
      r_we     <= 1'b0;
      r_cyc    <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_addr   <= bus.cmd_addr & ADDR_MASK;
            r_remain <= bus.cmd_len;
            r_we     <= bus.cmd_we;
            r_tmo    <= '0;
            if (bus.cmd_len == '0) begin
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_BURST;
              r_cyc   <= 1'b1;
            end
          end
        end
        ST_BURST: begin
          if (w_ack) begin
            r_addr   <= r_addr + ADDR_STEP;
            r_remain <= r_remain - 1'b1;
            r_tmo    <= '0;
            if (w_last) begin
              r_cyc   <= 1'b0;
              r_state <= ST_FINISH;
              r_done  <= 1'b1;
            end
          end else if (w_tmo_hit) begin
            r_cyc   <= 1'b0;
            r_tmo   <= '0;
            r_state <= ST_FINISH;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else if (w_stall) begin
            r_tmo <= r_tmo + 1'b1;
          end else begin
            r_tmo <= '0;
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready   = (r_state == ST_IDLE);
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.done        = r_done;
  assign bus.err         = r_err;
  assign bus.wdata_ready = ~w_fifo_full;

  assign bus.wb_cyc_o  = r_cyc;
  assign bus.wb_stb_o  = w_stb;
  assign bus.wb_we_o   = r_cyc & r_we;
  assign bus.wb_addr_o = r_addr;
  assign bus.wb_cti_o  = !r_cyc ? CTI_CLASSIC : (w_last ? CTI_EOB : CTI_INCR);
  assign bus.wb_dat_o  = w_fifo_head[dw-1:0];
  assign bus.wb_sel_o  = w_fifo_head[FW-1:dw];

  // Read beats leave in the ack cycle; the consumer has no way to stall them.
  assign bus.rdata_valid = w_rd_ack;
  assign bus.rdata       = w_rd_ack ? bus.wb_dat_i : '0;
  assign bus.rdata_last  = w_rd_ack & w_last;

endmodule
